// File: rtl/axi_rd_bridge_pkg.sv
// Shared encodings for the prefetcher-to-AXI read bridge: FSM states,
// request type codes and the fixed AXI AR attributes.
package axi_rd_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam logic [1:0] RD_TYPE_WORD  = 2'b00;
  localparam logic [1:0] RD_TYPE_LINE  = 2'b01;
  localparam logic [1:0] RD_TYPE_DLINE = 2'b10;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'd2;
  localparam logic [3:0] ARID_RD        = 4'd0;

  localparam int BEAT_W    = 32;
  localparam int NUM_BEATS = 16;

  // The reserved code 11 is served as a single 256-bit line.
  function automatic logic [1:0] norm_rd_type(input logic [1:0] t);
    return (t == 2'b11) ? RD_TYPE_LINE : t;
  endfunction

endpackage

// File: rtl/axi_rd_bridge_if.sv
// AXI4 read-address and read-data channels between the bridge (master)
// and the memory-side slave.
interface axi_rd_bridge_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/rd_line_buf.sv
// 16 x 32-bit beat buffer with a single write-by-index port; the whole
// buffer is presented as one 512-bit line, slot n at bits [32n+31:32n].
module rd_line_buf (
  input  logic         clk,
  input  logic         resetn,
  input  logic         wr_en,
  input  logic [3:0]   wr_idx,
  input  logic [31:0]  wr_data,
  output logic [511:0] line_o
);
  import axi_rd_bridge_pkg::*;

  logic [NUM_BEATS-1:0][BEAT_W-1:0] buf_q, buf_d;

  always_comb begin
    buf_d = buf_q;
    if (wr_en) buf_d[wr_idx] = wr_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) buf_q <= '0;
    else         buf_q <= buf_d;
  end

  assign line_o = buf_q;
endmodule

// File: rtl/axi_rd_bridge.sv
// Turns one prefetcher read request into a single AXI INCR burst and
// assembles the returned beats into a 512-bit response.
module axi_rd_bridge (
  input  logic            clk,
  input  logic            resetn,
  input  logic            rd_req,
  input  logic [1:0]      rd_type,
  input  logic [31:0]     rd_addr,
  output logic            rd_rdy,
  output logic            ret_valid,
  output logic [511:0]    ret_data,
  output logic            ret_half,
  axi_rd_bridge_if.master axi
);
  import axi_rd_bridge_pkg::*;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  type_q, type_d;
  logic [3:0]  beat_cnt_q, beat_cnt_d;
  logic        beat_ovf_q, beat_ovf_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        ret_valid_q, ret_valid_d;
  logic        ret_half_q, ret_half_d;
  logic        rd_rdy_q, rd_rdy_d;

  logic        beat_fire;
  logic        beat_wr;
  logic        unused_rsp;

  assign beat_fire = rready_q && axi.rvalid;
  // Once slot 15 has been filled, further beats are dropped until rlast.
  assign beat_wr   = beat_fire && !beat_ovf_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    type_d     = type_q;
    beat_cnt_d = beat_cnt_q;
    beat_ovf_d = beat_ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (rd_req && rd_rdy_q) begin
          addr_d     = rd_addr;
          type_d     = norm_rd_type(rd_type);
          beat_cnt_d = 4'd0;
          beat_ovf_d = 1'b0;
          state_d    = ST_AR;
        end
      end
      ST_AR: begin
        if (axi.arready) state_d = ST_R;
      end
      ST_R: begin
        if (beat_wr) begin
          if (beat_cnt_q == 4'd15) beat_ovf_d = 1'b1;
          else                     beat_cnt_d = beat_cnt_q + 4'd1;
        end
        if (beat_fire && axi.rlast) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    ret_half_d  = beat_wr && (type_q == RD_TYPE_DLINE) && (beat_cnt_q == 4'd7);
    arvalid_d   = (state_d == ST_AR);
    rready_d    = (state_d == ST_R);
    ret_valid_d = (state_d == ST_RESP);
    rd_rdy_d    = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      type_q      <= '0;
      beat_cnt_q  <= '0;
      beat_ovf_q  <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      ret_valid_q <= 1'b0;
      ret_half_q  <= 1'b0;
      rd_rdy_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      type_q      <= type_d;
      beat_cnt_q  <= beat_cnt_d;
      beat_ovf_q  <= beat_ovf_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      ret_valid_q <= ret_valid_d;
      ret_half_q  <= ret_half_d;
      rd_rdy_q    <= rd_rdy_d;
    end
  end

  // AR fields derive only from the latched request, so they hold still in AR.
  always_comb begin
    case (type_q)
      RD_TYPE_WORD: begin
        axi.araddr = addr_q;
        axi.arlen  = 8'd0;
      end
      RD_TYPE_DLINE: begin
        axi.araddr = {addr_q[31:6], 6'b0};
        axi.arlen  = 8'd15;
      end
      default: begin
        axi.araddr = {addr_q[31:5], 5'b0};
        axi.arlen  = 8'd7;
      end
    endcase
  end

  assign axi.arid    = ARID_RD;
  assign axi.arsize  = AXI_SIZE_4B;
  assign axi.arburst = AXI_BURST_INCR;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;

  assign rd_rdy    = rd_rdy_q;
  assign ret_valid = ret_valid_q;
  assign ret_half  = ret_half_q;

  // Single outstanding transaction: response ID and status carry no information.
  assign unused_rsp = ^{axi.rid, axi.rresp};

  rd_line_buf u_line_buf (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (beat_wr),
    .wr_idx  (beat_cnt_q),
    .wr_data (axi.rdata),
    .line_o  (ret_data)
  );
endmodule

// File: tb/tb_axi_rd_bridge.sv
// Randomized scoreboard bench for axi_rd_bridge: the driver plays the
// prefetcher and the AXI slave, a negedge monitor checks every response.
module tb_axi_rd_bridge;

  typedef struct {
    logic [1:0]   typ;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [511:0] data;
    bit           lat_chk;
  } txn_t;

  logic         clk;
  logic         resetn;
  logic         rd_req;
  logic [1:0]   rd_type;
  logic [31:0]  rd_addr;
  logic         rd_rdy;
  logic         ret_valid;
  logic [511:0] ret_data;
  logic         ret_half;

  axi_rd_bridge_if axi ();

  axi_rd_bridge dut (
    .clk       (clk),
    .resetn    (resetn),
    .rd_req    (rd_req),
    .rd_type   (rd_type),
    .rd_addr   (rd_addr),
    .rd_rdy    (rd_rdy),
    .ret_valid (ret_valid),
    .ret_data  (ret_data),
    .ret_half  (ret_half),
    .axi       (axi)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  txn_t        exp_q[$];
  logic [31:0] mline[16];
  logic [31:0] beat_data[32];

  bit          busy = 0;
  bit          half_due = 0;
  int          mon_beats = 0;
  int          acc_cyc = 0;
  txn_t        mt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s actual=timeout required=handshake (cycle %0d)", name, cyc);
  endtask

  // Monitor: AR fields, ret_half timing, rd_rdy while busy, and the scoreboard pop.
  always @(negedge clk) begin
    if (!resetn) begin
      busy      = 0;
      half_due  = 0;
      mon_beats = 0;
    end else begin
      if (axi.arvalid) begin
        if (exp_q.size() == 0) checkOutput("ar_unexpected", 512'(axi.arvalid), 512'(0));
        else begin
          checkOutput("araddr", 512'(axi.araddr), 512'(exp_q[0].araddr));
          checkOutput("arlen", 512'(axi.arlen), 512'(exp_q[0].arlen));
          checkOutput("ar_id_size_burst", 512'({axi.arid, axi.arsize, axi.arburst}),
                      512'({4'd0, 3'd2, 2'b01}));
        end
      end
      if (half_due || ret_half) checkOutput("ret_half", 512'(ret_half), 512'(half_due));
      half_due = axi.rvalid && axi.rready && (mon_beats == 7) &&
                 (exp_q.size() > 0) && (exp_q[0].typ == 2'b10);
      if (axi.rvalid && axi.rready) mon_beats++;
      if (busy) checkOutput("rd_rdy_busy", 512'(rd_rdy), 512'(0));
      if (ret_valid) begin
        if (exp_q.size() == 0) checkOutput("ret_valid_spurious", 512'(ret_valid), 512'(0));
        else begin
          mt = exp_q.pop_front();
          checkOutput("ret_data", ret_data, mt.data);
          checkOutput("rd_rdy_resp", 512'(rd_rdy), 512'(0));
          if (mt.lat_chk) checkOutput("latency", 512'(cyc - acc_cyc), 512'(3));
        end
        busy = 0;
      end
      if (rd_req && rd_rdy) begin
        busy      = 1;
        mon_beats = 0;
        acc_cyc   = cyc;
      end
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_rd_rdy"}, 512'(rd_rdy), 512'(0));
    checkOutput({tag, "_ret_valid"}, 512'(ret_valid), 512'(0));
    checkOutput({tag, "_ret_half"}, 512'(ret_half), 512'(0));
    checkOutput({tag, "_arvalid"}, 512'(axi.arvalid), 512'(0));
    checkOutput({tag, "_rready"}, 512'(axi.rready), 512'(0));
    checkOutput({tag, "_ret_data"}, ret_data, 512'(0));
  endtask

  // One request: reference expectations are pushed, then prefetcher and slave are driven.
  task automatic applyStimulus(input logic [1:0] typ, input logic [31:0] addr, input int nsend,
                               input int ar_delay, input int gap, input int rst_beat,
                               input bit lat_chk);
    txn_t t;
    logic [1:0] nt;
    int nb, waited, i, cyc_r;
    bit hs, ok, v;
    nt = (typ == 2'b11) ? 2'b01 : typ;
    nb = (nt == 2'b00) ? 1 : (nt == 2'b01) ? 8 : 16;
    t.typ     = nt;
    t.araddr  = (nt == 2'b00) ? addr : addr - (addr % (nb * 4));
    t.arlen   = 8'(nb - 1);
    t.lat_chk = lat_chk;
    for (int j = 0; j < nsend && j < 16; j++) mline[j] = beat_data[j];
    for (int j = 0; j < 16; j++) t.data[32*j +: 32] = mline[j];

    ok = 0;
    for (int k = 0; k < 50; k++) begin
      if (rd_rdy) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) begin timeoutFail("rd_rdy_wait"); return; end

    exp_q.push_back(t);
    rd_req      = 1'b1;
    rd_type     = typ;
    rd_addr     = addr;
    axi.arready = (ar_delay == 0);
    waited = 0;
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      hs = axi.arvalid && axi.arready;
      @(posedge clk); #1;
      if (k == 0) begin
        rd_req  = 1'b0;
        rd_addr = $urandom;
        rd_type = 2'($urandom);
      end
      if (hs) begin ok = 1; break; end
      if (axi.arvalid) begin
        waited++;
        axi.arready = (waited >= ar_delay);
      end
    end
    axi.arready = 1'b0;
    if (!ok) begin timeoutFail("ar_handshake"); exp_q.delete(); return; end

    i = 0;
    cyc_r = 0;
    ok = 0;
    for (int k = 0; k < 400; k++) begin
      v = (gap == 0) ? 1'b1 : (gap == 1) ? (cyc_r % 2 == 0) : ($urandom % 3 != 0);
      axi.rvalid = v;
      axi.rdata  = beat_data[i];
      axi.rlast  = (i == nsend - 1);
      axi.rid    = 4'($urandom);
      axi.rresp  = 2'($urandom);
      rd_req     = 1'($urandom);
      rd_addr    = $urandom;
      if (i == rst_beat) resetn = 1'b0;
      hs = v && axi.rready;
      @(posedge clk); #1;
      cyc_r++;
      if (!resetn) begin
        axi.rvalid = 1'b0;
        axi.rlast  = 1'b0;
        rd_req     = 1'b0;
        checkAllZero("midrst");
        exp_q.delete();
        for (int j = 0; j < 16; j++) mline[j] = 32'd0;
        resetn = 1'b1;
        @(posedge clk); #1;
        checkOutput("rd_rdy_after_midrst", 512'(rd_rdy), 512'(1));
        return;
      end
      if (hs) begin
        i++;
        if (i == nsend) begin ok = 1; break; end
      end
    end
    axi.rvalid = 1'b0;
    axi.rlast  = 1'b0;
    rd_req     = 1'b0;
    if (!ok) begin timeoutFail("r_beats"); exp_q.delete(); return; end

    ok = 0;
    for (int k = 0; k < 10; k++) begin
      if (exp_q.size() == 0) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) begin timeoutFail("ret_valid_wait"); exp_q.delete(); end
  endtask

  task automatic randomBeats(input int n);
    for (int j = 0; j < n; j++) beat_data[j] = $urandom;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0]  rt;
    logic [31:0] ra;
    int          nb, ns;
    resetn      = 1'b0;
    rd_req      = 1'b0;
    rd_type     = 2'b00;
    rd_addr     = 32'd0;
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rdata   = 32'd0;
    axi.rlast   = 1'b0;
    axi.rid     = 4'd0;
    axi.rresp   = 2'd0;
    for (int j = 0; j < 16; j++) mline[j] = 32'd0;

    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    resetn = 1'b1;
    checkOutput("rd_rdy_at_release", 512'(rd_rdy), 512'(0));
    @(posedge clk); #1;
    checkOutput("rd_rdy_after_release", 512'(rd_rdy), 512'(1));

    $display("[TB] word read, minimum latency");
    beat_data[0] = 32'hDEAD_BEEF;
    applyStimulus(2'b00, 32'h8000_0008, 1, 0, 0, -1, 1);

    $display("[TB] line read 0x1000_0024");
    for (int j = 0; j < 8; j++) beat_data[j] = 32'h11 + j;
    applyStimulus(2'b01, 32'h1000_0024, 8, 0, 0, -1, 0);

    $display("[TB] double line read 0x44");
    for (int j = 0; j < 16; j++) beat_data[j] = j;
    applyStimulus(2'b10, 32'h0000_0044, 16, 0, 0, -1, 0);

    $display("[TB] delayed arready, gapped rvalid");
    randomBeats(8);
    applyStimulus(2'b01, $urandom, 8, 5, 1, -1, 0);

    $display("[TB] early rlast on beat 3");
    randomBeats(4);
    applyStimulus(2'b01, $urandom, 4, 0, 0, -1, 0);

    $display("[TB] reset at beat 4, then reserved type");
    randomBeats(8);
    applyStimulus(2'b01, $urandom, 8, 0, 0, 4, 0);
    randomBeats(8);
    applyStimulus(2'b11, $urandom, 8, 1, 2, -1, 0);

    $display("[TB] overlong burst on double line");
    randomBeats(18);
    applyStimulus(2'b10, $urandom, 18, 0, 2, -1, 0);

    $display("[TB] random requests");
    for (int n = 0; n < 16; n++) begin
      rt = 2'($urandom);
      ra = $urandom;
      nb = (rt == 2'b00) ? 1 : (rt == 2'b10) ? 16 : 8;
      ns = ($urandom % 4 == 0) ? int'($urandom_range(1, nb)) : nb;
      randomBeats(ns);
      applyStimulus(rt, ra, ns, int'($urandom % 4), int'($urandom % 3), -1, 0);
    end

    repeat (4) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_rd_bridge.md
AXI_RD_BRIDGE -- requirements
Module: axi_rd_bridge

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-002 SHALL have port resetn, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port rd_req, input, 1 bit: prefetcher read request.
REQ-004 SHALL have port rd_type, input, 2 bits: 00 = word, 01 = 256-bit line, 10 = 512-bit double line, 11 = reserved.
REQ-005 SHALL have port rd_addr, input, 32 bits: request byte address.
REQ-006 SHALL have port rd_rdy, output, 1 bit: request accepted this cycle when rd_req&&rd_rdy.
REQ-007 SHALL have port ret_valid, output, 1 bit: one-cycle pulse, ret_data complete.
REQ-008 SHALL have port ret_data, output, 512 bits: assembled read data, beat n at bits [32n+31:32n].
REQ-009 SHALL have port ret_half, output, 1 bit: one-cycle pulse, ret_data[255:0] valid (type 10 only).
REQ-010 SHALL have AXI AR ports arid[3:0], araddr[31:0], arlen[7:0], arsize[2:0], arburst[1:0] and arvalid as outputs, and arready as an input.
REQ-011 SHALL have AXI R ports rid[3:0], rdata[31:0], rresp[1:0], rlast and rvalid as inputs, and rready as an output.

Function
REQ-012 SHALL implement the FSM IDLE -> AR -> R -> RESP -> IDLE.
REQ-013 SHALL assert rd_rdy only in IDLE; on acceptance it SHALL latch rd_addr and rd_type, clear the beat counter and go to AR.
REQ-014 SHALL treat rd_type 11 as 01.
REQ-015 SHALL hold arvalid=1 throughout AR with stable AR fields, and go to R on arvalid&&arready.
REQ-016 SHALL drive AR fields per type: 00: araddr=addr, arlen=0; 01: araddr={addr[31:5],5'b0}, arlen=7; 10: araddr={addr[31:6],6'b0}, arlen=15.
REQ-017 SHALL always drive arsize=2 (4 bytes), arburst=01 (INCR) and arid=0.
REQ-018 SHALL hold rready=1 in R only; on each rvalid&&rready it SHALL write rdata into slot beat_cnt and increment the 4-bit beat_cnt.
REQ-019 SHALL ignore rid and rresp; there is only one outstanding transaction.
REQ-020 SHALL, for type 10, pulse ret_half on the cycle after beat 7 is captured.
REQ-021 SHALL leave on rlast: the beat carrying rlast is captured, then the FSM goes to RESP.
REQ-022 SHALL accept an early rlast (fewer beats than arlen+1) without error; unreceived slots keep their stale contents.
REQ-023 SHALL saturate beat_cnt at 15 and discard beats beyond 16 if rlast never arrives, staying in R until rlast.
REQ-024 SHALL assert ret_valid=1 for exactly one cycle in RESP, with rd_rdy=0 in that cycle, then return to IDLE.
REQ-025 SHALL hold ret_data stable from RESP until the next accepted request's first captured beat.
REQ-026 SHALL have a minimum request-to-ret_valid latency of 3 cycles for type 00 (arready and rvalid immediate).
REQ-027 SHALL ignore a rd_req outside IDLE (rd_rdy=0).

Reset
REQ-028 SHALL, while resetn=0 at a clock edge, set state to IDLE, beat_cnt to 0, and arvalid, rready, ret_valid, ret_half and rd_rdy to 0; rd_rdy SHALL rise the cycle after release.
REQ-029 SHALL clear ret_data and the latched addr and type to 0 on reset.
REQ-030 SHALL, on reset mid-transaction, abandon the transaction with no ret_valid; the AXI slave is reset by the same resetn.

Structure
REQ-031 SHALL take from the shared package: state encodings, RD_TYPE_WORD/LINE/DLINE codes, AXI_BURST_INCR, AXI_SIZE_4B and ARID_RD.
REQ-032 SHALL put the 16x32 beat buffer with its write-by-index port in one sub-module, rd_line_buf; all other logic stays in axi_rd_bridge.

Verification
REQ-033 SHALL cover: type 01, addr 0x1000_0024, arready immediate, 8 beats 0x11..0x18 -> araddr=0x1000_0020, arlen=7, ret_data[255:0] beats in order, ret_valid 1 cycle, ret_half never.
REQ-034 SHALL cover: type 10, addr 0x0000_0044, 16 beats of value k -> araddr=0x40, arlen=15, ret_half the cycle after beat 7, ret_valid after beat 15, ret_data[511:480]=15.
REQ-035 SHALL cover: type 00, addr 0x8000_0008, rdata 0xDEADBEEF -> arlen=0, ret_data[31:0]=0xDEADBEEF, ret_valid at cycle 3.
REQ-036 SHALL cover: arready delayed 5 cycles, rvalid gaps every other cycle -> AR fields stable while waiting, data correct, rd_rdy low until after RESP.
REQ-037 SHALL cover: resetn=0 at beat 4 of a type 01 burst -> next cycle all outputs 0, no ret_valid, and a new request is served correctly.
REQ-038 SHALL cover: rlast on beat 3 of type 01 -> RESP entered, ret_valid pulses, beats 0-3 correct.
